// File: rtl/axi_rr_arbiter_rab_pkg.sv
// Shared types and helpers for the RAB round-robin arbiter.
// Holds the FSM state enum, the wait counter width and the pointer wrap helper.
package axi_arb_rab_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_e;

   localparam int WAIT_CNT_W = 16;

   function automatic int unsigned rr_next(
      input int unsigned ptr,
      input int unsigned num_req
   );
      return (ptr + 1 >= num_req) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/axi_rr_pick_rab.sv
// Rotating priority encoder: first set bit of req, searching upward from ptr.
// Ports: req (request vector), ptr (start index), found, idx (winner).
module axi_rr_pick_rab
   import axi_arb_rab_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic               found,
   output logic [IW-1:0]      idx
);

   // One extra bit so ptr+k can be compared to NUM_REQ before wrapping.
   logic [IW:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr} + (IW+1)'(k);
         if (pos >= (IW+1)'(NUM_REQ)) begin
            pos = pos - (IW+1)'(NUM_REQ);
         end
         if (!found && req[pos[IW-1:0]]) begin
            found = 1'b1;
            idx   = pos[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/axi_rr_arbiter_rab.sv
// Burst-locked round-robin arbiter sharing one valid/ready channel.
// Ports: clk, rst (async high), valid_in/data_in/last_in/ready_out (up),
//        data_out/last_out/valid_out/ready_in (down), grant_id, busy.
// Optional: AXI_ARB_RAB_WAIT_CNT_EN adds wait_cnt, 16 bits per requester.
module axi_rr_arbiter_rab
   import axi_arb_rab_pkg::*;
#(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 64,
   localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            valid_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
   input  logic [NUM_REQ-1:0]            last_in,
   output logic [NUM_REQ-1:0]            ready_out,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          last_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic [ID_WIDTH-1:0]           grant_id,
   output logic                          busy
`ifdef AXI_ARB_RAB_WAIT_CNT_EN
   ,
   output logic [NUM_REQ*WAIT_CNT_W-1:0] wait_cnt
`endif
);

   arb_state_e          state;
   logic [ID_WIDTH-1:0] rr_ptr;
   logic                pick_found;
   logic [ID_WIDTH-1:0] pick_idx;
   logic                hs;
   logic [ID_WIDTH-1:0] ptr_after;

   axi_rr_pick_rab #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req   (valid_in),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Channel mux; everything is held at 0 unless locked to an owner.
   always_comb begin
      valid_out = 1'b0;
      data_out  = '0;
      last_out  = 1'b0;
      ready_out = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (busy && grant_id == ID_WIDTH'(i)) begin
            valid_out    = valid_in[i];
            data_out     = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            last_out     = last_in[i];
            ready_out[i] = ready_in;
         end
      end
   end

   assign hs        = valid_out & ready_in;
   assign ptr_after = ID_WIDTH'(rr_next(32'(grant_id), 32'(NUM_REQ)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB_IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
      end else begin
         unique case (state)
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_id <= pick_idx;
                  busy     <= 1'b1;
                  state    <= ARB_LOCKED;
               end
            end
            ARB_LOCKED: begin
               // Only the last beat releases; a stalled owner keeps the lock.
               if (hs && last_out) begin
                  rr_ptr <= ptr_after;
                  busy   <= 1'b0;
                  state  <= ARB_IDLE;
               end
            end
            default: begin
               state <= ARB_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef AXI_ARB_RAB_WAIT_CNT_EN
   logic [WAIT_CNT_W-1:0] cnt [NUM_REQ];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (valid_in[i] &&
                !(busy && grant_id == ID_WIDTH'(i)) &&
                cnt[i] != '1) begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      wait_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         wait_cnt[i*WAIT_CNT_W +: WAIT_CNT_W] = cnt[i];
      end
   end
`endif

endmodule

// File: tb/tb_axi_rr_arbiter_rab.sv
// Directed self-checking bench for axi_rr_arbiter_rab (4 requesters).
// Wait counter checks build only with AXI_ARB_RAB_WAIT_CNT_EN defined.
module tb_axi_rr_arbiter_rab;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   valid_in;
   logic [255:0] data_in;
   logic [3:0]   last_in;
   logic [3:0]   ready_out;
   logic [63:0]  data_out;
   logic         last_out;
   logic         valid_out;
   logic         ready_in;
   logic [1:0]   grant_id;
   logic         busy;
`ifdef AXI_ARB_RAB_WAIT_CNT_EN
   logic [63:0]  wait_cnt;
`endif

   int total = 0;
   int bad   = 0;

   axi_rr_arbiter_rab #(
      .NUM_REQ    (4),
      .DATA_WIDTH (64)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .last_in   (last_in),
      .ready_out (ready_out),
      .data_out  (data_out),
      .last_out  (last_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .grant_id  (grant_id),
      .busy      (busy)
`ifdef AXI_ARB_RAB_WAIT_CNT_EN
      ,
      .wait_cnt  (wait_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   int exp_g [6] = '{3, 0, 1, 2, 3, 0};
   int b;

   initial begin
      rst      = 1'b1;
      valid_in = '0;
      last_in  = '0;
      data_in  = '0;
      ready_in = 1'b0;

      // reset then idle
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_vout", valid_out, 0);
         chk("rst_rdy", ready_out, 0);
         @(posedge clk);
      end
      #1;
      rst = 1'b0;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_rdy", ready_out, 0);
      chk("idle_data", data_out, 0);

      // single requester, 3-beat burst
      valid_in = 4'b0100;
      ready_in = 1'b1;
      data_in[2*64 +: 64] = 64'hD1;
      #1;
      chk("s_idle_vout", valid_out, 0);
      chk("s_idle_rdy", ready_out, 0);
      tick();
      chk("s_busy", busy, 1);
      chk("s_gid", grant_id, 2);
      chk("s_rdy", ready_out, 4'b0100);
      chk("s_d1", data_out, 64'hD1);
      chk("s_l1", last_out, 0);
      tick();
      data_in[2*64 +: 64] = 64'hD2;
      #1;
      chk("s_d2", data_out, 64'hD2);
      chk("s_v2", valid_out, 1);
      tick();
      data_in[2*64 +: 64] = 64'hD3;
      last_in = 4'b0100;
      #1;
      chk("s_d3", data_out, 64'hD3);
      chk("s_l3", last_out, 1);
      tick();
      chk("s_done", busy, 0);

      // round robin, single-beat bursts, pointer starts at 3
      valid_in = 4'b1111;
      last_in  = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         data_in[i*64 +: 64] = 64'hC0 + 64'(i);
      end
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_bubble", busy, 0);
         tick();
         chk("rr_gid", grant_id, 64'(exp_g[k]));
         chk("rr_rdy", ready_out, 64'(1 << exp_g[k]));
         chk("rr_data", data_out, 64'hC0 + 64'(exp_g[k]));
         tick();
      end

      // burst lock with backpressure, pointer now 1
      valid_in = 4'b0011;
      last_in  = 4'b0000;
      data_in[0 +: 64] = 64'hE0;
      tick();
      chk("bl_gid", grant_id, 1);
      for (int c = 0; c < 7; c++) begin
         b = (c + 1) / 2;
         ready_in = (c % 2 == 0);
         last_in  = (b == 3) ? 4'b0010 : 4'b0000;
         data_in[64 +: 64] = 64'h100 + 64'(b);
         #1;
         chk("bl_busy", busy, 1);
         chk("bl_rdy", ready_out, {2'b00, ready_in, 1'b0});
         chk("bl_data", data_out, 64'h100 + 64'(b));
         tick();
      end
      valid_in = 4'b0001;
      last_in  = 4'b0000;
      ready_in = 1'b1;
      #1;
      chk("bl_idle", busy, 0);
      chk("bl_idle_rdy", ready_out, 0);
      tick();
      chk("bl_next_gid", grant_id, 0);
      chk("bl_next_rdy", ready_out, 4'b0001);
      chk("bl_next_data", data_out, 64'hE0);

      // owner drops valid mid-burst, then reset mid-burst
      tick();
      tick();
      valid_in = 4'b0000;
      #1;
      chk("drop_busy", busy, 1);
      chk("drop_vout", valid_out, 0);
      tick();
      chk("drop_hold", busy, 1);
      valid_in = 4'b0001;
      rst = 1'b1;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_rdy", ready_out, 0);
      chk("mr_vout", valid_out, 0);
      chk("mr_data", data_out, 0);
      tick();
      rst      = 1'b0;
      valid_in = 4'b1111;
      last_in  = 4'b1111;
      tick();
      chk("mr_gid", grant_id, 0);
      chk("mr_busy2", busy, 1);

`ifdef AXI_ARB_RAB_WAIT_CNT_EN
      // requester 3 waits behind a long burst from requester 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("wc_clr", wait_cnt, 0);
      valid_in = 4'b0001;
      last_in  = 4'b0000;
      ready_in = 1'b1;
      tick();
      chk("wc_gid0", grant_id, 0);
      valid_in = 4'b1001;
      for (int k = 0; k < 9; k++) begin
         if (k == 8) last_in = 4'b0001;
         tick();
      end
      valid_in = 4'b1000;
      last_in  = 4'b0000;
      tick();
      chk("wc_gid3", grant_id, 3);
      chk("wc_cnt3", wait_cnt[48 +: 16], 10);

      // saturation: requester 0 waits while 3 is stalled
      valid_in = 4'b1001;
      ready_in = 1'b0;
      for (int k = 0; k < 70000; k++) begin
         @(posedge clk);
      end
      #1;
      chk("wc_sat0", wait_cnt[0 +: 16], 16'hFFFF);
      chk("wc_sat_busy", busy, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
